// File: rtl/matmul_rect_if.sv
// matmul_rect_if
//   Host-side bus of the rectangular matrix-multiply tile: the start/acc_mode
//   control, the busy/done/wr_err status, the X and Y load ports and the Z
//   read port. Address widths follow the matrix dimensions, so the interface
//   must be given the same DATA_WIDTH/M_DIM/K_DIM/N_DIM as the tile.
//   master : host side (drives control, load and read-address signals)
//   slave  : tile side (drives status and z_dout)
interface matmul_rect_if #(
    parameter int DATA_WIDTH = 32,
    parameter int M_DIM      = 8,
    parameter int K_DIM      = 8,
    parameter int N_DIM      = 8
);
    localparam int XA = (M_DIM * K_DIM > 1) ? $clog2(M_DIM * K_DIM) : 1;
    localparam int YA = (K_DIM * N_DIM > 1) ? $clog2(K_DIM * N_DIM) : 1;
    localparam int ZA = (M_DIM * N_DIM > 1) ? $clog2(M_DIM * N_DIM) : 1;

    logic                  start;
    logic                  acc_mode;
    logic                  busy;
    logic                  done;
    logic                  wr_err;
    logic [XA-1:0]         x_wr_addr;
    logic                  x_wr_en;
    logic [DATA_WIDTH-1:0] x_din;
    logic [YA-1:0]         y_wr_addr;
    logic                  y_wr_en;
    logic [DATA_WIDTH-1:0] y_din;
    logic [ZA-1:0]         z_rd_addr;
    logic [DATA_WIDTH-1:0] z_dout;

    modport master (
        output start, acc_mode, x_wr_addr, x_wr_en, x_din,
               y_wr_addr, y_wr_en, y_din, z_rd_addr,
        input  busy, done, wr_err, z_dout
    );

    modport slave (
        input  start, acc_mode, x_wr_addr, x_wr_en, x_din,
               y_wr_addr, y_wr_en, y_din, z_rd_addr,
        output busy, done, wr_err, z_dout
    );
endinterface

// File: rtl/matmul_rect_top.sv
// matmul_rect_top
//   Compute tile for Z[M][N] = X[M][K] * Y[K][N] (or Z += X*Y in accumulate
//   mode) with LANES output columns computed in parallel. X, Y and Z live in
//   private RAMs that the host loads/reads through the bus interface.
//   Ports:
//     clock : single clock, everything on posedge
//     reset : asynchronous, active-low
//     bus   : matmul_rect_if.slave (start/acc_mode in, busy/done/wr_err out,
//             X/Y write ports, registered Z read port with 1-cycle latency)
//   Y and Z are split into LANES banks by column (j mod LANES) so one group
//   of LANES columns is read/written in a single cycle.
module matmul_rect_top #(
    parameter int DATA_WIDTH = 32,
    parameter int M_DIM      = 8,
    parameter int K_DIM      = 8,
    parameter int N_DIM      = 8,
    parameter int LANES      = 2
) (
    input  logic         clock,
    input  logic         reset,
    matmul_rect_if.slave bus
);
    localparam int XA     = (M_DIM * K_DIM > 1) ? $clog2(M_DIM * K_DIM) : 1;
    localparam int YA     = (K_DIM * N_DIM > 1) ? $clog2(K_DIM * N_DIM) : 1;
    localparam int ZA     = (M_DIM * N_DIM > 1) ? $clog2(M_DIM * N_DIM) : 1;
    localparam int GROUPS = N_DIM / LANES;
    localparam int YB     = K_DIM * GROUPS;
    localparam int ZB     = M_DIM * GROUPS;
    localparam int YBA    = (YB > 1) ? $clog2(YB) : 1;
    localparam int ZBA    = (ZB > 1) ? $clog2(ZB) : 1;
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW     = (M_DIM > 1) ? $clog2(M_DIM) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int KW     = (K_DIM > 1) ? $clog2(K_DIM) : 1;

    if ((LANES < 1) || (N_DIM % LANES != 0)) begin : g_bad_lanes
        $error("matmul_rect_top: LANES (%0d) must divide N_DIM (%0d)", LANES, N_DIM);
    end

    typedef enum logic [2:0] {
        S_IDLE, S_PRELOAD, S_MAC, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         i_q, i_d;
    logic [GW-1:0]         g_q, g_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_err_q, wr_err_d;
    logic                  acc_mode_q, acc_mode_d;
    logic [DATA_WIDTH-1:0] z_dout_q, z_dout_d;
    logic                  z_we;
    logic                  x_we, y_we;
    logic [XA-1:0]         x_rd_addr;
    logic [YBA-1:0]        y_rd_addr, y_wr_bank;
    logic [ZBA-1:0]        z_addr, z_rd_bank;
    logic [LW-1:0]         y_wr_lane, z_rd_lane;
    logic [DATA_WIDTH-1:0] x_rd_q;
    logic [DATA_WIDTH-1:0] x_mem [M_DIM*K_DIM];
    logic [LANES-1:0][DATA_WIDTH-1:0] z_host_rd;

    // Host writes are only honoured while idle; the rest is bank decoding.
    // N_DIM is a multiple of LANES, so a linear address mod LANES is its column's lane.
    assign x_we      = bus.x_wr_en && !busy_q;
    assign y_we      = bus.y_wr_en && !busy_q;
    assign y_wr_lane = LW'(bus.y_wr_addr % YA'(LANES));
    assign y_wr_bank = YBA'(bus.y_wr_addr / YA'(LANES));
    assign z_rd_lane = LW'(bus.z_rd_addr % ZA'(LANES));
    assign z_rd_bank = ZBA'(bus.z_rd_addr / ZA'(LANES));

    // Every lane of a group shares one bank address: row*GROUPS + group.
    assign x_rd_addr = XA'(32'(i_q) * K_DIM + 32'(k_q));
    assign y_rd_addr = YBA'(32'(k_q) * GROUPS + 32'(g_q));
    assign z_addr    = ZBA'(32'(i_q) * GROUPS + 32'(g_q));

    always_ff @(posedge clock) begin
        if (x_we) begin
            x_mem[bus.x_wr_addr] <= bus.x_din;
        end
        x_rd_q <= x_mem[x_rd_addr];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] y_mem [YB];
        logic [DATA_WIDTH-1:0] z_mem [ZB];
        logic [DATA_WIDTH-1:0] y_rd_q, z_rd_q;
        logic [DATA_WIDTH-1:0] acc_q, acc_d;

        always_ff @(posedge clock) begin
            if (y_we && (y_wr_lane == LW'(l))) begin
                y_mem[y_wr_bank] <= bus.y_din;
            end
            if (z_we) begin
                z_mem[z_addr] <= acc_q;
            end
            y_rd_q <= y_mem[y_rd_addr];
            z_rd_q <= z_mem[z_addr];
        end

        assign z_host_rd[l] = z_mem[z_rd_bank];

        // Reads lag by a cycle: the first MAC cycle seeds acc from the Z value
        // fetched in PRELOAD, later MAC cycles and DRAIN add the previous k's
        // product. The low DATA_WIDTH bits of a two's-complement product do not
        // depend on signedness, so a DATA_WIDTH-wide multiply gives the wrapped result.
        always_comb begin
            acc_d = acc_q;
            if ((state_q == S_MAC) && (k_q == '0)) begin
                acc_d = acc_mode_q ? z_rd_q : '0;
            end else if ((state_q == S_MAC) || (state_q == S_DRAIN)) begin
                acc_d = acc_q + x_rd_q * y_rd_q;
            end
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                acc_q <= '0;
            end else begin
                acc_q <= acc_d;
            end
        end
    end

    // Loop order is row i, then column group g, then k. On the first DONE cycle
    // busy is still high; that cycle raises done and drops busy, which gives the
    // one extra cycle between the final Z write and done.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        g_d        = g_q;
        k_d        = k_q;
        busy_d     = busy_q;
        done_d     = done_q;
        wr_err_d   = wr_err_q;
        acc_mode_d = acc_mode_q;
        z_we       = 1'b0;
        z_dout_d   = z_host_rd[z_rd_lane];

        if ((bus.x_wr_en || bus.y_wr_en) && busy_q) begin
            wr_err_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (busy_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (bus.start) begin
                    state_d    = S_PRELOAD;
                    i_d        = '0;
                    g_d        = '0;
                    k_d        = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    wr_err_d   = 1'b0;
                    acc_mode_d = bus.acc_mode;
                end
            end
            S_PRELOAD: state_d = S_MAC;
            S_MAC: begin
                if (k_q == KW'(K_DIM - 1)) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                z_we    = 1'b1;
                state_d = S_PRELOAD;
                if (g_q == GW'(GROUPS - 1)) begin
                    g_d = '0;
                    if (i_q == IW'(M_DIM - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            g_q        <= '0;
            k_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            acc_mode_q <= 1'b0;
            z_dout_q   <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            g_q        <= g_d;
            k_q        <= k_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_err_q   <= wr_err_d;
            acc_mode_q <= acc_mode_d;
            z_dout_q   <= z_dout_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wr_err = wr_err_q;
    assign bus.z_dout = z_dout_q;
endmodule
